instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch front-end that sits between the instruction memory (test_mem: addr[4:0] out, DIN[15:0] in, synchronous read) and the processor datapath.
- Drives the memory address from an internal program counter and captures each returned word into an instruction register.
- For a 2-word mvi, also fetches the immediate word.
- Presents {instruction, immediate} to the processor with a valid/ready handshake.

Parameters:
- ADDR_W, 5, program-counter and memory-address width.
- DATA_W, 16, memory word width.
- OP_MVI, 3'b001, opcode (word bits [8:6]) that requires an immediate word.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  enable fetching; sampled in IDLE only.
- addr  out  ADDR_W  memory address (= pc).
- DIN  in  DATA_W  memory read data, valid one cycle after addr.
- instr  out  9  captured instruction word bits [8:0] (III XXX YYY).
- imm  out  DATA_W  immediate word; 0 when instruction is not mvi.
- instr_valid  out  1  instr/imm are valid and stable.
- instr_ready  in  1  processor accepts the instruction this cycle.
- pc_out  out  ADDR_W  address of the presented instruction word.

Behaviour:
- Reset (async, active-high) sets outputs and state: pc=0, addr=0, instr=0, imm=0, instr_valid=0, pc_out=0, state=IDLE.
- Memory model: addr is registered by the memory; DIN reflects addr from the previous cycle. Fetch latency is one wait cycle per word.
- States: IDLE, WAIT_I, CAP_I, WAIT_M, CAP_M, HOLD.
- IDLE: if run=1, go to WAIT_I; addr already equals pc.
- WAIT_I: memory read in flight; go to CAP_I.
- CAP_I:
  - Capture instr<=DIN[8:0] and pc_out<=pc; then pc<=pc+1.
  - If DIN[8:6]==OP_MVI, go to WAIT_M.
  - Otherwise imm<=0 and go to HOLD.
- WAIT_M: addr=pc (the immediate address); go to CAP_M.
- CAP_M: imm<=DIN, pc<=pc+1, go to HOLD.
- HOLD:
  - instr_valid=1.
  - instr, imm and pc_out are held constant while instr_ready=0.
  - On instr_ready=1: instr_valid falls next cycle; go to WAIT_I if run=1, else IDLE.
- instr_valid is registered. It is high only in HOLD.
- Wrap-around: pc increments modulo 2^ADDR_W (31 -> 0). An mvi at address 31 takes its immediate from address 0.
- run deasserted mid-fetch: the current instruction completes to HOLD and is delivered, then the unit parks in IDLE.
- instr_ready while not in HOLD is ignored.
- Reset mid-operation: any in-flight fetch is discarded; restart from pc=0.
- Minimum throughput: 3 cycles per 1-word instruction and 5 per mvi, when instr_ready is held high.

Optional Feature:
- Macro FETCH_HALT_EN.
- Defined:
  - Opcode 3'b111 is a halt. It is delivered once through HOLD like any instruction.
  - After acceptance the unit enters a HALTED state. HALTED ignores run and leaves only on reset. An extra output port halted (1 bit) is 1 in HALTED.
- Undefined: 3'b111 is an ordinary 1-word instruction; no halted port, no HALTED state.

Decomposition:
- Shared package holds:
  - state encoding constants for IDLE/WAIT_I/CAP_I/WAIT_M/CAP_M/HOLD/HALTED;
  - opcode constants (OP_MV=000, OP_MVI=001, OP_ADD=010, OP_SUB=011, OP_HALT=111);
  - field positions for instruction bits [8:6]/[5:3]/[2:0].
- Natural sub-module: fetch_pc. It holds the ADDR_W-bit wrapping counter with inc/clear and async reset. The FSM and capture registers stay in the top level.

Test Plan:
- Reset then run=1, instr_ready=1. Mem[0]=9'b000_001_010 (mv). Required: instr_valid rises 3 cycles after run; instr=0x00A, imm=0, pc_out=0, addr=1.
- Mem[1]=9'b001_011_000 (mvi), Mem[2]=16'hBEEF. Required: instr=0x058, imm=0xBEEF, pc_out=1, next pc=3, 5 cycles from start of fetch.
- Backpressure: hold instr_ready=0 for 10 cycles in HOLD. Required: instr_valid stays 1, instr/imm/pc_out unchanged, addr unchanged; single transfer on release.
- Wrap: preload pc path to 31 with mvi at 31, immediate at Mem[0]=16'h1234. Required: imm=0x1234, pc becomes 1.
- Drop run during WAIT_I. Required: the instruction is still delivered, then IDLE, with no further addr change.
- Assert reset during WAIT_M. Required: all outputs immediately 0 (async); after release with run=1, fetch resumes at addr=0. With FETCH_HALT_EN: opcode 111 accepted -> halted=1, addr frozen despite run=1.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// Optional halt support (FETCH_HALT_EN) uses StHalted and OpHalt from here.
package instr_fetch_unit_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StWaitI  = 3'd1,
      StCapI   = 3'd2,
      StWaitM  = 3'd3,
      StCapM   = 3'd4,
      StHold   = 3'd5,
      StHalted = 3'd6
   } fetch_state_e;

   localparam logic [2:0] OpMv   = 3'b000;
   localparam logic [2:0] OpMvi  = 3'b001;
   localparam logic [2:0] OpAdd  = 3'b010;
   localparam logic [2:0] OpSub  = 3'b011;
   localparam logic [2:0] OpHalt = 3'b111;

   // Instruction word layout: III XXX YYY
   localparam int unsigned InstrW    = 9;
   localparam int unsigned OpcodeMsb = 8;
   localparam int unsigned OpcodeLsb = 6;
   localparam int unsigned RxMsb     = 5;
   localparam int unsigned RxLsb     = 3;
   localparam int unsigned RyMsb     = 2;
   localparam int unsigned RyLsb     = 0;

   function automatic logic [2:0] opcode_of(input logic [InstrW-1:0] word);
      return word[OpcodeMsb:OpcodeLsb];
   endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_pc.sv
// Program counter for the fetch unit: ADDR_W-bit counter that wraps modulo
// 2^ADDR_W, with increment and synchronous clear.
module instr_fetch_unit_fetch_pc #(
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inc,
   input  logic              clr,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (clr) begin
         pc_d = '0;
      end else if (inc) begin
         pc_d = pc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front-end: reads instruction (and mvi immediate) words from a
// synchronous-read memory and presents them with a valid/ready handshake.
// Define FETCH_HALT_EN to treat opcode 111 as halt and add the halted port.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 16,
   parameter logic [2:0]  OP_MVI = OpMvi
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   output logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] DIN,
   output logic [InstrW-1:0] instr,
   output logic [DATA_W-1:0] imm,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [ADDR_W-1:0] pc_out
`ifdef FETCH_HALT_EN
   ,
   output logic              halted
`endif
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc;
   logic              pc_inc;
   logic              cap_i;
   logic              cap_m;
   logic [InstrW-1:0] instr_q;
   logic [DATA_W-1:0] imm_q;
   logic [ADDR_W-1:0] pc_out_q;
   logic              valid_q;
   logic              valid_d;

   instr_fetch_unit_fetch_pc #(
      .ADDR_W (ADDR_W)
   ) u_fetch_pc (
      .clk   (clk),
      .reset (reset),
      .inc   (pc_inc),
      .clr   (1'b0),
      .pc    (pc)
   );

   always_comb begin
      state_d = state_q;
      pc_inc  = 1'b0;
      cap_i   = 1'b0;
      cap_m   = 1'b0;
      case (state_q)
         StIdle: begin
            if (run) state_d = StWaitI;
         end
         StWaitI: begin
            state_d = StCapI;
         end
         StCapI: begin
            cap_i   = 1'b1;
            pc_inc  = 1'b1;
            state_d = (DIN[OpcodeMsb:OpcodeLsb] == OP_MVI) ? StWaitM : StHold;
         end
         StWaitM: begin
            state_d = StCapM;
         end
         StCapM: begin
            cap_m   = 1'b1;
            pc_inc  = 1'b1;
            state_d = StHold;
         end
         StHold: begin
            if (instr_ready) begin
               state_d = run ? StWaitI : StIdle;
`ifdef FETCH_HALT_EN
               if (opcode_of(instr_q) == OpHalt) state_d = StHalted;
`endif
            end
         end
`ifdef FETCH_HALT_EN
         StHalted: begin
            state_d = StHalted;
         end
`endif
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Valid is registered and therefore tracks exactly the cycles spent in StHold.
   assign valid_d = (state_d == StHold);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         instr_q  <= '0;
         imm_q    <= '0;
         pc_out_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         if (cap_i) begin
            instr_q  <= DIN[InstrW-1:0];
            pc_out_q <= pc;
            imm_q    <= '0;
         end
         if (cap_m) begin
            imm_q <= DIN;
         end
      end
   end

   assign addr        = pc;
   assign instr       = instr_q;
   assign imm         = imm_q;
   assign instr_valid = valid_q;
   assign pc_out      = pc_out_q;
`ifdef FETCH_HALT_EN
   assign halted      = (state_q == StHalted);
`endif

endmodule
